// File: rtl/period_meter.sv
// period_meter -- measures one period (and optionally the high phase) of a
// slow, possibly asynchronous square wave in clk cycles, on request.
//
// Optional feature macro: PERIOD_METER_HIGH_TIME_EN
//   defined   -> high_time port, its register and fall detection present
//   undefined -> high_time port and logic absent, falling edges ignored
//
// Ports:
//   clk        in   system clock, all registers on its rising edge
//   rst_n      in   asynchronous active-low reset
//   sig_in     in   signal under measurement (asynchronous to clk)
//   start      in   one-cycle measurement request, honoured only in IDLE
//   ack        in   consumer acknowledge, honoured only in DONE
//   busy       out  high while arming or measuring
//   valid      out  high while a result is presented
//   timeout    out  qualifies valid: measurement was aborted
//   period     out  clk cycles between two consecutive rising edges
//   high_time  out  clk cycles from the opening rise to the next fall
//   state_o    out  debug view of the FSM state (0=IDLE 1=ARM 2=MEASURE 3=DONE)
//
// Handshake: valid rises the cycle after the closing edge (or timeout) and
// period/high_time/timeout are stable for as long as valid is high; the
// consumer raises ack for one cycle and valid falls on the following cycle.
module period_meter #(
  parameter int          CNT_W       = 26,
  parameter int unsigned TIMEOUT_CYC = 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
`ifdef PERIOD_METER_HIGH_TIME_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, valid_q;

  // Synchronizer and registered edge detector. The pipeline always runs, so
  // an edge already in flight when ARM is entered opens the measurement.
  logic sync1_q, sync2_q, prev_q, rise_q;

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic             fall_q;
  logic             fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0] high_q, high_d;
`endif

  logic             cnt_at_lim;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_at_lim = (cnt_q == LIMIT);
  // Saturating increment: the counter never wraps past the limit.
  assign cnt_inc    = cnt_at_lim ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      fall_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
`ifdef PERIOD_METER_HIGH_TIME_EN
      fall_q  <= ~sync2_q & prev_q;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    timeout_d = timeout_q;
`ifdef PERIOD_METER_HIGH_TIME_EN
    high_d      = high_q;
    fall_seen_d = fall_seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d   = S_ARM;
          period_d  = '0;
          timeout_d = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
          high_d      = '0;
          fall_seen_d = 1'b0;
`endif
        end
      end
      S_ARM: begin
        if (rise_q) begin
          // The rise cycle is reference cycle a; the next cycle reads 1.
          state_d = S_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_at_lim) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_inc;
`ifdef PERIOD_METER_HIGH_TIME_EN
        if (fall_q && !fall_seen_q) begin
          high_d      = cnt_q;
          fall_seen_d = 1'b1;
        end
`endif
        if (rise_q) begin
          state_d   = S_DONE;
          period_d  = cnt_q;
          timeout_d = 1'b0;
        end else if (cnt_at_lim) begin
          // high_time keeps whatever was latched (0 if no fall was seen).
          state_d   = S_DONE;
          period_d  = '0;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        // ack wins over a simultaneous start; start here is dropped.
        if (ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      high_q      <= '0;
      fall_seen_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == S_ARM) || (state_d == S_MEASURE);
      valid_q   <= (state_d == S_DONE);
`ifdef PERIOD_METER_HIGH_TIME_EN
      high_q      <= high_d;
      fall_seen_q <= fall_seen_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign period  = period_q;
  assign state_o = state_q;
`ifdef PERIOD_METER_HIGH_TIME_EN
  assign high_time = high_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: a free-running square-wave generator with a
// random phase to clk feeds sig_in; expected periods and high times come
// from the generator settings (period = high + low, high_time = high).
module tb_period_meter;

  localparam int         CNT_W   = 8;
  localparam int         TO      = 50;
  localparam logic [1:0] IDLE_ST = 2'd0;
  localparam logic [1:0] MEAS_ST = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic ack = 1'b0;
  logic gen_en = 1'b0;
  logic gen_sig = 1'b0;
  logic man_sig = 1'b0;
  logic sig_in;
  int   hi_cyc = 12;
  int   lo_cyc = 8;

  assign sig_in = gen_en ? gen_sig : man_sig;

  logic             busy, valid, timeout;
  logic [CNT_W-1:0] period;
  logic [1:0]       state_o;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] exp_hi_q[$];
`endif

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_q[$];

  period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .ack       (ack),
    .busy      (busy),
    .valid     (valid),
    .timeout   (timeout),
    .period    (period),
`ifdef PERIOD_METER_HIGH_TIME_EN
    .high_time (high_time),
`endif
    .state_o   (state_o)
  );

  // Square wave: edges land on whole clk periods from a random start phase.
  initial begin
    forever begin
      wait (gen_en);
      gen_sig = 1'b1;
      #(hi_cyc * 10);
      gen_sig = 1'b0;
      #(lo_cyc * 10);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit now);
    if (!now) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for two generator rises so the next full period uses the new shape.
  task automatic settle_gen();
    repeat (2) @(posedge sig_in);
  endtask

  task automatic do_ack(input string name);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || state_o !== IDLE_ST)
      $display("FAIL %s ack: valid=%0b state=%0d, required valid=0 state=%0d",
               name, valid, state_o, IDLE_ST);
    if (valid !== 1'b0 || state_o !== IDLE_ST) errors++;
  endtask

  // ---------------- scoreboard check of one measurement ----------------
  task automatic measure_and_check(input string name, input int hi, input int lo,
                                   input bit now);
    logic [CNT_W-1:0] exp;
    bit busy_ok;
    int n;
    exp_q.push_back(CNT_W'(hi + lo));
`ifdef PERIOD_METER_HIGH_TIME_EN
    exp_hi_q.push_back(CNT_W'(hi));
`endif
    pulse_start(now);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %0b required 1", name, busy);
    end
    busy_ok = 1'b1;
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_wait: valid=%0b after %0d cycles, required 1", name, valid, n);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_window: held=%0b at_valid=%0b required held=1 at_valid=0",
               name, busy_ok, busy);
    end
    exp = exp_q.pop_front();
    checks++;
    if (period !== exp) begin
      errors++;
      $display("FAIL %s period: got %0d required %0d", name, period, exp);
    end
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: got %0b required 0", name, timeout);
    end
`ifdef PERIOD_METER_HIGH_TIME_EN
    exp = exp_hi_q.pop_front();
    checks++;
    if (high_time !== exp) begin
      errors++;
      $display("FAIL %s high_time: got %0d required %0d", name, high_time, exp);
    end
`endif
  endtask

  task automatic check_all_zero(input string name);
    logic [CNT_W-1:0] ht;
`ifdef PERIOD_METER_HIGH_TIME_EN
    ht = high_time;
`else
    ht = '0;
`endif
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0 || period !== '0 ||
        ht !== '0 || state_o !== IDLE_ST) begin
      errors++;
      $display("FAIL %s reset_outputs: busy=%0b valid=%0b timeout=%0b period=%0d high=%0d state=%0d, required all 0",
               name, busy, valid, timeout, period, ht, state_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    hi_cyc = 12;
    lo_cyc = 8;
    @(negedge clk);
    #($urandom_range(1, 4));
    gen_en = 1'b1;
    settle_gen();
    measure_and_check("single", 12, 8, 1'b0);
  endtask

  task automatic test_hold_ack();
    bit stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid !== 1'b1 || period !== CNT_W'(20)) stable = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      if (high_time !== CNT_W'(12)) stable = 1'b0;
`endif
      start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold: result changed while waiting for ack, now valid=%0b period=%0d required 1/20",
               valid, period);
    end
    // ack and start together: only ack is acted on.
    @(negedge clk);
    ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || state_o !== IDLE_ST) begin
      errors++;
      $display("FAIL hold ack_start: valid=%0b state=%0d required 0/%0d", valid, state_o, IDLE_ST);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || state_o !== IDLE_ST) begin
      errors++;
      $display("FAIL hold start_dropped: busy=%0b state=%0d required 0/%0d", busy, state_o, IDLE_ST);
    end
  endtask

  task automatic test_random();
    int hi, lo;
    for (int i = 0; i < 6; i++) begin
      hi = $urandom_range(2, 20);
      lo = $urandom_range(2, 20);
      hi_cyc = hi;
      lo_cyc = lo;
      settle_gen();
      measure_and_check($sformatf("random%0d", i), hi, lo, 1'b0);
      do_ack($sformatf("random%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    hi_cyc = 5;
    lo_cyc = 4;
    settle_gen();
    measure_and_check("b2b_first", 5, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      measure_and_check($sformatf("b2b%0d", i), 5, 4, 1'b1);
    end
    do_ack("b2b_last");
  endtask

  task automatic test_ignored();
    int n;
    hi_cyc = 7;
    lo_cyc = 9;
    settle_gen();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    pulse_start(1'b0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n = 0;
    while (state_o !== MEAS_ST && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid !== 1'b1 || period !== CNT_W'(16) || timeout !== 1'b0) begin
      errors++;
      $display("FAIL ignored: valid=%0b period=%0d timeout=%0b required 1/16/0",
               valid, period, timeout);
    end
`ifdef PERIOD_METER_HIGH_TIME_EN
    checks++;
    if (high_time !== CNT_W'(7)) begin
      errors++;
      $display("FAIL ignored high_time: got %0d required 7", high_time);
    end
`endif
    do_ack("ignored");
  endtask

  task automatic test_reset_done();
    hi_cyc = 6;
    lo_cyc = 6;
    settle_gen();
    measure_and_check("reset_done_meas", 6, 6, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_in_done");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    hi_cyc = 10;
    lo_cyc = 10;
    settle_gen();
    pulse_start(1'b0);
    n = 0;
    while (state_o !== MEAS_ST && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_measure");
    @(negedge clk);
    rst_n = 1'b1;
    settle_gen();
    measure_and_check("after_reset", 10, 10, 1'b0);
    do_ack("after_reset");
  endtask

  task automatic test_timeout_idle();
    int n;
    gen_en = 1'b0;
    man_sig = 1'b0;
    repeat (6) @(negedge clk);
    pulse_start(1'b0);
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid !== 1'b1 || n != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: valid=%0b after %0d cycles, required 1 after %0d",
               valid, n, TO + 1);
    end
    checks++;
    if (timeout !== 1'b1 || period !== '0) begin
      errors++;
      $display("FAIL timeout_result: timeout=%0b period=%0d required 1/0", timeout, period);
    end
`ifdef PERIOD_METER_HIGH_TIME_EN
    checks++;
    if (high_time !== '0) begin
      errors++;
      $display("FAIL timeout_high: got %0d required 0", high_time);
    end
`endif
    do_ack("timeout_idle");
  endtask

  task automatic test_timeout_fall();
    int n;
    man_sig = 1'b0;
    pulse_start(1'b0);
    repeat (4) @(negedge clk);
    man_sig = 1'b1;
    repeat (7) @(negedge clk);
    man_sig = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid !== 1'b1 || timeout !== 1'b1 || period !== '0) begin
      errors++;
      $display("FAIL timeout_fall: valid=%0b timeout=%0b period=%0d required 1/1/0",
               valid, timeout, period);
    end
`ifdef PERIOD_METER_HIGH_TIME_EN
    checks++;
    if (high_time !== CNT_W'(7)) begin
      errors++;
      $display("FAIL timeout_fall high_time: got %0d required 7", high_time);
    end
`endif
    do_ack("timeout_fall");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_hold_ack();
    test_random();
    test_back_to_back();
    test_ignored();
    test_reset_done();
    test_reset_mid();
    test_timeout_idle();
    test_timeout_fall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Synchronous period and pulse-width meter for the slow square waves the divider chain produces, such as the ~1 Hz tick. Where the divider turns `clk` into a slow signal, this block turns a slow, possibly asynchronous signal back into a cycle count of `clk`. It measures one period on request and presents the result with a valid/ack handshake to the display or control logic.

## Interface
- `CNT_W`, 26: width of the cycle counter and result ports. Holds 50 000 000 at 50 MHz.
- `TIMEOUT_CYC`, 2**CNT_W-1: elapsed-cycle limit, in any waiting or measuring phase, that aborts the measurement.
- `clk` in 1: system clock; every register is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sig_in` in 1: signal under measurement; asynchronous to `clk`.
- `start` in 1: one-cycle request to begin a measurement; accepted only in IDLE.
- `ack` in 1: consumer acknowledge; accepted only in DONE.
- `busy` out 1: high in ARM and MEASURE.
- `valid` out 1: high in DONE.
- `timeout` out 1: qualifies `valid`; high means the measurement was aborted.
- `period` out CNT_W: `clk` cycles between two consecutive rising edges of `sig_in`.
- `high_time` out CNT_W: `clk` cycles from the opening rising edge to the following falling edge. Present only with the Configuration macro.

## Operation
- `sig_in` passes through a 2-FF synchronizer, then a registered edge detector that produces a one-cycle `rise` pulse and a one-cycle `fall` pulse.
- **IDLE**: counter is 0. `start`=1 moves to ARM.
- **ARM**: waits for `rise`.
  - On `rise`, go to MEASURE; this cycle is the reference cycle a.
  - If the counter reaches TIMEOUT_CYC first, go to DONE with `timeout`=1.
- **MEASURE**: the counter runs from cycle a.
  - On the first `fall` (cycle f), latch `high_time` = f-a.
  - On the next `rise` (cycle b), latch `period` = b-a, `timeout`=0, and go to DONE.
  - If elapsed cycles reach TIMEOUT_CYC, go to DONE with `timeout`=1, `period`=0, and `high_time`=0 if no `fall` was seen.
- **DONE**: results and `valid` are held stable. `ack`=1 returns to IDLE. `start` is ignored.
- Ignored inputs:
  - `start` outside IDLE.
  - `ack` outside DONE.
  - `start` and `ack` together in DONE: only `ack` is acted on.
- The counter saturates at TIMEOUT_CYC and never wraps.
- Reset values, all 0: state (IDLE), `busy`, `valid`, `timeout`, `period`, `high_time`, counter, synchronizer and edge registers.
- Asserting `rst_n` mid-measurement aborts it immediately; no result is produced.

## Timing
- Input latency: a `sig_in` transition appears as `rise`/`fall` 3 `clk` edges after capture (2 synchronizer + 1 edge register).
  - Measured values are differences between pulse cycles, so this fixed latency cancels out.
- Outputs are registered:
  - `busy` rises the cycle after `start` is sampled.
  - `valid` rises the cycle after the closing `rise` (or timeout).
  - `valid` falls the cycle after `ack` is sampled.
- Earliest re-arm: `start` in the first IDLE cycle after DONE.
- Minimum measurable signal:
  - high and low phases of at least 2 `clk` cycles each;
  - `period` ≥ 4.
  - Shorter phases may be missed by the synchronizer; this is not an error condition.
- An edge already in the edge-detect pipeline when ARM is entered is a valid opening edge.

## Configuration
- `PERIOD_METER_HIGH_TIME_EN`
  - Defined: the `high_time` port, its register and the `fall` detection are compiled in, with the behaviour above.
  - Undefined: the `high_time` port and its logic are absent; MEASURE ignores falling edges; all other behaviour is identical.

## Test plan
- `sig_in` at 12 cycles high / 8 low, phase-random to `clk`; pulse `start` → `valid`=1, `period`=20, `high_time`=12, `timeout`=0; `busy` high until the `valid` cycle.
- Hold `valid` without `ack` for 100 cycles while `sig_in` keeps toggling → `period`/`high_time` unchanged; `ack` → `valid`=0 next cycle, state IDLE.
- `sig_in` stuck low, TIMEOUT_CYC=50, pulse `start` → `valid`=1, `timeout`=1, `period`=0 exactly 51 cycles after `start`.
- `start` pulsed during MEASURE, plus `ack` pulsed outside DONE → no effect; the result matches an undisturbed run.
- `rst_n`=0 mid-MEASURE → all outputs 0 asynchronously; a new `start` after release yields a correct `period`.
- Macro undefined, same stimulus as scenario 1 → `period`=20, no `high_time` port, build passes.
